// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the current transaction
//   FULL_BE : byte-enable mask used for instruction fetches
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [3:0] FULL_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
//   slave  : view taken by the arbiter (requests and memory answers in,
//            grants/responses and memory command out)
//   master : view taken by the surrounding core and memory
//   if_*   : instruction-fetch requester (read only)
//   dm_*   : load/store requester
//   mem_*  : unified memory port
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  logic                  dm_req;
  logic                  dm_we;
  logic [3:0]            dm_be;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_err;

  logic                  mem_req;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata, dm_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker (purely combinational).
//   req[1:0]   : bit 0 = IF request, bit 1 = DM request
//   last_owner : owner of the most recently completed transaction
//   gnt[1:0]   : one-hot pick, all zero when nothing is requested
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // on a tie the requester that was not served last wins
      2'b11:   gnt = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch (IF) and load/store
// (DM) requesters. One transaction outstanding at a time, round-robin
// arbitration, and an error response if memory stays silent for TIMEOUT
// cycles after accepting a request.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : requester and memory signals (slave view)
//
// state | meaning
// IDLE  | no transaction; arbitrates unless a response is being delivered
// REQ   | mem_req driven with the captured command, waiting for mem_gnt
// RSP   | waiting for mem_rvalid, timeout counter running
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  // a registered response takes one cycle, so the decision is made on the
  // count one below TIMEOUT to land the error pulse exactly TIMEOUT cycles
  // after entering RSP
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);

  state_t                state_q, state_d;
  owner_t                owner_q, last_owner_q, pick;
  logic [7:0]            cnt_q;
  logic [1:0]            req_vec, gnt_vec;
  logic                  arb_en, capture, rsp_done, rsp_err;

  logic                  mem_req_q, mem_we_q;
  logic [3:0]            mem_be_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  if_rvalid_q, if_err_q, dm_rvalid_q, dm_err_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q;

  assign req_vec = {bus.dm_req, bus.if_req};

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last_owner (last_owner_q),
    .gnt        (gnt_vec)
  );

  assign pick = gnt_vec[1] ? OWN_DM : OWN_IF;

  always_comb begin
    state_d  = state_q;
    arb_en   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    rsp_err  = 1'b0;
    case (state_q)
      IDLE: begin
        // the cycle carrying a response pulse is not an arbitration cycle
        arb_en = !reset && !(if_rvalid_q || dm_rvalid_q);
        if (arb_en && (gnt_vec != 2'b00)) begin
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt) state_d = RSP;
      end
      RSP: begin
        // a response on the expiry cycle still counts as a good response
        if (bus.mem_rvalid) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_done = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rvalid_q  <= 1'b0;
      dm_err_q     <= 1'b0;
      dm_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_err_q    <= 1'b0;

      if (capture) begin
        owner_q   <= pick;
        mem_req_q <= 1'b1;
        if (pick == OWN_DM) begin
          mem_we_q    <= bus.dm_we;
          mem_be_q    <= bus.dm_be;
          mem_addr_q  <= bus.dm_addr;
          mem_wdata_q <= bus.dm_wdata;
        end else begin
          mem_we_q    <= 1'b0;
          mem_be_q    <= FULL_BE;
          mem_addr_q  <= bus.if_addr;
          mem_wdata_q <= '0;
        end
      end

      if (state_q == REQ && bus.mem_gnt) begin
        mem_req_q <= 1'b0;
        cnt_q     <= '0;
      end else if (state_q == RSP && cnt_q < CNT_MAX) begin
        cnt_q <= cnt_q + 8'd1;
      end

      if (rsp_done) begin
        last_owner_q <= owner_q;
        if (owner_q == OWN_DM) begin
          dm_rvalid_q <= 1'b1;
          dm_err_q    <= rsp_err;
          dm_rdata_q  <= rsp_err ? '0 : bus.mem_rdata;
        end else begin
          if_rvalid_q <= 1'b1;
          if_err_q    <= rsp_err;
          if_rdata_q  <= rsp_err ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_gnt    = capture & gnt_vec[0];
  assign bus.dm_gnt    = capture & gnt_vec[1];
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT = 8).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // one transaction episode: stimulus plus expected owner/command/response
  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] rdata;
    int          gnt_dly;   // cycles mem_gnt stays low in REQ
    int          rsp_dly;   // RSP cycle index of mem_rvalid; >= TO means never
    logic        stray;     // extra mem_rvalid while in REQ
    logic        exp_own;   // 0 = IF, 1 = DM
    logic        exp_we;
    logic [3:0]  exp_be;
    logic        exp_err;
  } txn_t;

  txn_t tbl[8];

  function automatic txn_t mk(logic ifr, logic dmr, logic we, logic [3:0] be,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] wd,
                              logic [31:0] rd, int gd, int rdl, logic stray,
                              logic own, logic ewe, logic [3:0] ebe, logic eerr);
    txn_t t;
    t.if_req = ifr;   t.dm_req = dmr;   t.dm_we = we;     t.dm_be = be;
    t.if_addr = ia;   t.dm_addr = da;   t.dm_wdata = wd;  t.rdata = rd;
    t.gnt_dly = gd;   t.rsp_dly = rdl;  t.stray = stray;
    t.exp_own = own;  t.exp_we = ewe;   t.exp_be = ebe;   t.exp_err = eerr;
    return t;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, id, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_be = '0;
    bus.dm_addr = '0;   bus.dm_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input int id);
    chk("z_mem_req",   id, bus.mem_req,   0);
    chk("z_mem_we",    id, bus.mem_we,    0);
    chk("z_mem_be",    id, bus.mem_be,    0);
    chk("z_mem_addr",  id, bus.mem_addr,  0);
    chk("z_mem_wdata", id, bus.mem_wdata, 0);
    chk("z_if_gnt",    id, bus.if_gnt,    0);
    chk("z_dm_gnt",    id, bus.dm_gnt,    0);
    chk("z_if_rvalid", id, bus.if_rvalid, 0);
    chk("z_dm_rvalid", id, bus.dm_rvalid, 0);
    chk("z_if_rdata",  id, bus.if_rdata,  0);
    chk("z_dm_rdata",  id, bus.dm_rdata,  0);
    chk("z_if_err",    id, bus.if_err,    0);
    chk("z_dm_err",    id, bus.dm_err,    0);
  endtask

  // Runs one episode starting in an arbitration-ready IDLE cycle (cycle 0):
  // gnt in cycle 0, mem_req from cycle 1 until mem_gnt, RSP from cycle
  // 2+gnt_dly, owner response one cycle after mem_rvalid or TO cycles after
  // entering RSP. The losing requester keeps requesting the whole time.
  task automatic run_txn(input txn_t t, input int id);
    int gd, r0, mv, resp;
    logic own;
    logic [31:0] exp_addr, exp_wdata;
    gd = t.gnt_dly;
    r0 = 2 + gd;
    if (t.rsp_dly < TO) begin
      mv   = r0 + t.rsp_dly;
      resp = mv + 1;
    end else begin
      mv   = -1;
      resp = r0 + TO;
    end
    own       = t.exp_own;
    exp_addr  = own ? t.dm_addr : t.if_addr;
    exp_wdata = own ? t.dm_wdata : 32'h0;
    bus.if_addr  = t.if_addr;
    bus.dm_addr  = t.dm_addr;
    bus.dm_we    = t.dm_we;
    bus.dm_be    = t.dm_be;
    bus.dm_wdata = t.dm_wdata;
    for (int c = 0; c <= resp; c++) begin
      bus.if_req     = t.if_req && (c == 0 || own);
      bus.dm_req     = t.dm_req && (c == 0 || !own);
      bus.mem_gnt    = (c == 1 + gd);
      bus.mem_rvalid = (c == mv) || (t.stray && gd > 0 && c == 1);
      bus.mem_rdata  = (c == mv) ? t.rdata : $urandom();
      @(negedge clk);
      chk("if_gnt",    id, bus.if_gnt,    (c == 0) && !own);
      chk("dm_gnt",    id, bus.dm_gnt,    (c == 0) && own);
      chk("mem_req",   id, bus.mem_req,   (c >= 1) && (c <= 1 + gd));
      if (c == 1 || c == 1 + gd) begin
        chk("mem_we",    id, bus.mem_we,    t.exp_we);
        chk("mem_be",    id, bus.mem_be,    t.exp_be);
        chk("mem_addr",  id, bus.mem_addr,  exp_addr);
        chk("mem_wdata", id, bus.mem_wdata, exp_wdata);
      end
      chk("if_rvalid", id, bus.if_rvalid, (c == resp) && !own);
      chk("dm_rvalid", id, bus.dm_rvalid, (c == resp) && own);
      if (c == resp) begin
        chk("own_err",   id, own ? bus.dm_err : bus.if_err, t.exp_err);
        chk("own_rdata", id, own ? bus.dm_rdata : bus.if_rdata,
            t.exp_err ? 32'h0 : t.rdata);
        chk("other_err", id, own ? bus.if_err : bus.dm_err, 0);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        prev_acc, dmturn, last, own;
    int          ph, r;
    txn_t        t;

    //            ifr dmr we be    if_addr       dm_addr       wdata         rdata       gd rd st own we be    err
    tbl[0] = mk(1, 0, 0, 4'h0, 32'h100,      32'h0,        32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0, 4'hF, 0);
    tbl[1] = mk(0, 1, 1, 4'h3, 32'h0,        32'h2004,     32'h1234,     32'hA5A50000, 5, 1, 1, 1, 1, 4'h3, 0);
    tbl[2] = mk(1, 1, 1, 4'h6, 32'h200,      32'h3000,     32'h77,       32'h11112222, 1, 2, 0, 0, 0, 4'hF, 0);
    tbl[3] = mk(1, 1, 0, 4'hC, 32'h204,      32'h3004,     32'h0,        32'h33334444, 0, 7, 0, 1, 0, 4'hC, 0);
    tbl[4] = mk(0, 1, 0, 4'hF, 32'h0,        32'h3008,     32'h0,        32'h55556666, 0, 8, 0, 1, 0, 4'hF, 1);
    tbl[5] = mk(1, 1, 1, 4'h1, 32'h208,      32'h300C,     32'h99,       32'h0BAD0BAD, 2, 20, 0, 0, 0, 4'hF, 1);
    tbl[6] = mk(1, 0, 0, 4'h0, 32'h20C,      32'h0,        32'h0,        32'hCAFEF00D, 2, 3, 0, 0, 0, 4'hF, 0);
    tbl[7] = mk(1, 1, 1, 4'hF, 32'h210,      32'h4000,     32'hFEEDFACE, 32'h12345678, 0, 0, 0, 1, 1, 4'hF, 0);

    // reset state
    drive_idle();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_all_zero(0);
    next_cycle();
    reset = 1'b0;

    // both requesters held continuously: DM, IF, DM, IF, one access per 4 cycles
    bus.if_addr = 32'h400;
    bus.dm_addr = 32'h5000;
    bus.dm_be   = 4'hF;
    prev_acc    = 1'b0;
    for (int c = 0; c < 16; c++) begin
      bus.if_req     = 1'b1;
      bus.dm_req     = 1'b1;
      bus.mem_gnt    = 1'b1;
      bus.mem_rvalid = prev_acc;
      bus.mem_rdata  = 32'hA0000000 + 32'(c);
      @(negedge clk);
      ph     = c % 4;
      dmturn = ((c / 4) % 2) == 0;
      chk("rr_if_gnt",    c, bus.if_gnt,    (ph == 0) && !dmturn);
      chk("rr_dm_gnt",    c, bus.dm_gnt,    (ph == 0) && dmturn);
      if (ph == 1)
        chk("rr_mem_addr", c, bus.mem_addr, dmturn ? 32'h5000 : 32'h400);
      chk("rr_if_rvalid", c, bus.if_rvalid, (ph == 3) && !dmturn);
      chk("rr_dm_rvalid", c, bus.dm_rvalid, (ph == 3) && dmturn);
      if (ph == 3)
        chk("rr_rdata", c, dmturn ? bus.dm_rdata : bus.if_rdata,
            32'hA0000000 + 32'(c - 1));
      prev_acc = bus.mem_req && bus.mem_gnt;
      next_cycle();
    end
    drive_idle();
    next_cycle();

    // table of single-transaction vectors
    for (int i = 0; i < 8; i++) run_txn(tbl[i], 10 + i);

    // stray mem_rvalid while idle
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5A5A5A5A;
    @(negedge clk);
    chk("stray_if_rvalid", 0, bus.if_rvalid, 0);
    chk("stray_dm_rvalid", 0, bus.dm_rvalid, 0);
    next_cycle();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_if_rvalid", 1, bus.if_rvalid, 0);
    chk("stray_dm_rvalid", 1, bus.dm_rvalid, 0);
    chk("stray_mem_req",   1, bus.mem_req,   0);
    next_cycle();

    // reset in the middle of RSP aborts silently and restores the tie-break
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h7000;
    bus.dm_be   = 4'hF;
    @(negedge clk);
    chk("abort_dm_gnt", 0, bus.dm_gnt, 1);
    next_cycle();
    bus.dm_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    chk("abort_mem_req", 1, bus.mem_req, 1);
    next_cycle();
    bus.mem_gnt = 1'b0;
    next_cycle();
    reset          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBADDCAFE;
    next_cycle();
    reset          = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk_all_zero(1);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      chk("abort_if_rvalid", c, bus.if_rvalid, 0);
      chk("abort_dm_rvalid", c, bus.dm_rvalid, 0);
    end
    next_cycle();
    run_txn(mk(1, 1, 0, 4'hF, 32'h600, 32'h7004, 32'h0, 32'h0F0F0F0F,
               0, 1, 0, 1, 0, 4'hF, 0), 30);

    // randomized episodes against a transaction-level model
    last = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r          = int'($urandom_range(1, 3));
      t.if_req   = r[0];
      t.dm_req   = r[1];
      t.dm_we    = 1'($urandom_range(0, 1));
      t.dm_be    = 4'($urandom_range(0, 15));
      t.if_addr  = $urandom() & 32'hFFFF_FFFC;
      t.dm_addr  = $urandom();
      t.dm_wdata = $urandom();
      t.rdata    = $urandom();
      t.gnt_dly  = int'($urandom_range(0, 3));
      t.rsp_dly  = int'($urandom_range(0, TO + 2));
      t.stray    = 1'($urandom_range(0, 1));
      // both active: the one not served last; otherwise the only one active
      own        = (t.if_req && t.dm_req) ? !last : t.dm_req;
      t.exp_own  = own;
      t.exp_we   = own ? t.dm_we : 1'b0;
      t.exp_be   = own ? t.dm_be : 4'hF;
      t.exp_err  = (t.rsp_dly >= TO);
      run_txn(t, 100 + i);
      last = own;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
